score_sequencer: RTL and testbench
==================================

# score_sequencer

Game-level score controller that owns the value shown on the two-digit seven-segment score display. It counts rounds won, tracks a session high score, and decides what the display shows in each game phase. It drives the display block's `number`/`change_score` load interface with single-cycle load strobes. It sits between the game FSM (event pulses) and the display driver.

## Interface
Parameters:
- `FLASH_CYCLES`, default 25_000_000: cycles each value is held while alternating in OVER. Must be ≥ 2.
- `MAX_SCORE`, default 99: saturation limit. Must be ≤ 99 (two display digits).

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `game_start`  in  1  one-cycle pulse: begin a new game.
- `round_won`  in  1  one-cycle pulse: add 1 to the current score.
- `game_over`  in  1  one-cycle pulse: end the current game.
- `number`  out  8  value for the display to load; binary, range 0..MAX_SCORE.
- `change_score`  out  1  one-cycle load strobe; `number` is valid whenever this is high.
- `new_high`  out  1  level; high while in OVER if the finished game beat the previous high score.
- `phase`  out  2  current state: 0 = IDLE, 1 = PLAY, 2 = OVER.

## Operation
- Registers:
  - `score` (7b) and `high` (7b).
  - `state`.
  - `show_high` flag.
  - Flash counter, width clog2(FLASH_CYCLES).
  - `pending` push flag.
- States:
  - IDLE: display shows `high`.
  - PLAY: display shows `score`.
  - OVER: display alternates between `score` and `high`, starting with `score`.
- Transitions and event effects (event priority within one cycle: game_start > game_over > round_won):
  - `game_start` in any state: go to PLAY, `score` <= 0, `new_high` <= 0, push.
  - `game_over` in PLAY: go to OVER.
    - If `score` > `high`: `high` <= `score` and `new_high` <= 1.
    - Clear the flash counter, `show_high` <= 0, push.
  - `game_over` outside PLAY: ignored.
  - `round_won` in PLAY: `score` <= min(`score` + 1, MAX_SCORE), push. At MAX_SCORE the score saturates with no wrap, and the push still occurs.
  - `round_won` outside PLAY, or in the same cycle as `game_over` or `game_start`: dropped.
- Flash in OVER:
  - The counter increments every cycle.
  - At FLASH_CYCLES−1 it wraps to 0, toggles `show_high`, and pushes.
- The display value is selected as follows:
  - IDLE: `high`.
  - PLAY: `score`.
  - OVER: `show_high` ? `high` : `score`.
- Push mechanism:
  - Any event that pushes sets the outputs on the next edge: `number` <= the new display value and `change_score` <= 1.
  - `change_score` is never high for two consecutive cycles unless two consecutive pushing events occur.
- Outputs are registered only. There are no combinational paths from inputs to outputs.

## Timing
- Reset values (asynchronous, while `resetn` = 0):
  - `state` = IDLE, `score` = 0, `high` = 0.
  - `number` = 0, `change_score` = 0, `new_high` = 0, `phase` = 0.
  - Flash counter = 0, `show_high` = 0, `pending` = 1.
- First rising edge after `resetn` deasserts: `change_score` = 1 with `number` = 0 for one cycle (initial display load), then `pending` clears.
- Event-to-output latency: an event pulse sampled at edge N produces the updated `number` with `change_score` = 1 after edge N, held for exactly one cycle.
- `number` holds its last value whenever `change_score` = 0.
- OVER cadence: strobes occur every FLASH_CYCLES cycles after entry. The first alternation (to `high`) lands FLASH_CYCLES cycles after the entry strobe.
- Reset mid-game discards `score` and `high`. Reset mid-flash returns to IDLE immediately.
- Input pulses longer than one cycle are treated as one event per cycle; the game FSM must supply single-cycle pulses.

## Configuration
- `SCORE_HIGH_EN` defined (default build): high-score register, `new_high`, and OVER alternation as described above.
- `SCORE_HIGH_EN` undefined:
  - The `high` register, flash counter, and `show_high` are removed.
  - `new_high` is tied to 0.
  - IDLE displays 0; OVER displays `score` steadily with no flash strobes.
  - Port list and `FLASH_CYCLES` are unchanged (parameter unused).

## Test plan
- Reset release → exactly one `change_score` pulse with `number` = 0 on the first edge; `phase` = 0.
- `game_start`, then 3× `round_won` spaced 2 cycles apart → four strobes with `number` = 0, 1, 2, 3; each strobe lands 1 cycle after its pulse.
- `game_start`, then 105 `round_won` pulses → `number` reaches 99 and stays 99; a strobe accompanies every pulse.
- Play to score 5 then `game_over` with `high` = 0 → `new_high` = 1, strobe `number` = 5. With FLASH_CYCLES = 4: strobes with `number` = 5, 4 cycles later 5 again? No: `high` now equals 5, so every strobe shows 5. Repeat with a second game scoring 2 → alternating strobes 2, 5, 2, 5 every 4 cycles and `new_high` = 0.
- `round_won` and `game_over` in the same cycle at score 7 → OVER entered, `number` = 7, increment dropped. `game_start` and `game_over` in the same cycle → PLAY, `number` = 0.
- Assert `resetn` low during OVER mid-count → outputs go to reset values immediately without waiting for a clock edge; after release, the initial load strobe is issued with `number` = 0.

Source files
------------

// File: rtl/score_sequencer.sv
// score_sequencer: owns the two-digit score display value and issues single-cycle load strobes.
// Define SCORE_HIGH_EN to add the session high score, new_high and the OVER score/high flash.
module score_sequencer #(
  parameter int FLASH_CYCLES = 25_000_000,
  parameter int MAX_SCORE    = 99
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       game_start,
  input  logic       round_won,
  input  logic       game_over,
  output logic [7:0] number,
  output logic       change_score,
  output logic       new_high,
  output logic [1:0] phase
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  state_t     state_q, state_d;
  logic [6:0] score_q, score_d, disp_d;
  logic [7:0] number_q, number_d;
  logic       pending_q, push_d, change_q, new_high_q, new_high_d;
`ifdef SCORE_HIGH_EN
  localparam int CW = $clog2(FLASH_CYCLES);
  logic [6:0]    high_q, high_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          show_high_q, show_high_d, wrap;
  assign wrap = cnt_q == CW'(FLASH_CYCLES - 1);
`else
  logic unused_flash;
  assign unused_flash = |FLASH_CYCLES;
`endif
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    new_high_d = new_high_q;
    push_d     = pending_q;
`ifdef SCORE_HIGH_EN
    high_d      = high_q;
    cnt_d       = cnt_q;
    show_high_d = show_high_q;
`endif
    if (game_start) begin
      state_d    = PLAY;
      score_d    = '0;
      new_high_d = 1'b0;
      push_d     = 1'b1;
    end else if (game_over && state_q == PLAY) begin
      state_d = OVER;
      push_d  = 1'b1;
`ifdef SCORE_HIGH_EN
      if (score_q > high_q) begin
        high_d     = score_q;
        new_high_d = 1'b1;
      end
      cnt_d       = '0;
      show_high_d = 1'b0;
`endif
    end else if (round_won && state_q == PLAY) begin
      score_d = (score_q >= 7'(MAX_SCORE)) ? score_q : score_q + 7'd1;
      push_d  = 1'b1;
    end
`ifdef SCORE_HIGH_EN
    else if (state_q == OVER) begin
      cnt_d       = wrap ? '0 : cnt_q + CW'(1);
      show_high_d = show_high_q ^ wrap;
      push_d      = push_d | wrap;
    end
    disp_d = (state_d == IDLE) ? high_d :
             (state_d == PLAY) ? score_d :
             show_high_d ? high_d : score_d;
`else
    disp_d = (state_d == IDLE) ? 7'd0 : score_d;
`endif
    // Outputs are loaded with the post-edge display value so the strobe lands one edge after the event.
    number_d = push_d ? {1'b0, disp_d} : number_q;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      score_q    <= '0;
      pending_q  <= 1'b1;
      number_q   <= '0;
      change_q   <= 1'b0;
      new_high_q <= 1'b0;
`ifdef SCORE_HIGH_EN
      high_q      <= '0;
      cnt_q       <= '0;
      show_high_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      pending_q  <= 1'b0;
      number_q   <= number_d;
      change_q   <= push_d;
      new_high_q <= new_high_d;
`ifdef SCORE_HIGH_EN
      high_q      <= high_d;
      cnt_q       <= cnt_d;
      show_high_q <= show_high_d;
`endif
    end
  end
  assign number       = number_q;
  assign change_score = change_q;
  assign new_high     = new_high_q;
  assign phase        = state_q;
endmodule

// File: tb/tb_score_sequencer.sv
// tb_score_sequencer: directed and random pulses checked every cycle against a game-level reference model.
module tb_score_sequencer;
  localparam int F   = 4;
  localparam int MAX = 99;
`ifdef SCORE_HIGH_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic       clock = 1'b0;
  logic       resetn, game_start, round_won, game_over;
  logic [7:0] number;
  logic       change_score, new_high;
  logic [1:0] phase;
  int n_err = 0, n_chk = 0;
  int m_phase, m_score, m_high, m_t, m_num;
  bit m_nh, m_first, m_chg;

  score_sequencer #(.FLASH_CYCLES(F), .MAX_SCORE(MAX)) dut (
    .clock(clock), .resetn(resetn), .game_start(game_start), .round_won(round_won),
    .game_over(game_over), .number(number), .change_score(change_score),
    .new_high(new_high), .phase(phase)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_score = 0; m_high = 0; m_t = 0; m_num = 0;
    m_nh = 0; m_first = 1; m_chg = 0;
  endtask

  // Game rules: t counts cycles since OVER entry; the display flips every F cycles starting on score.
  task automatic model_step(input bit gs, input bit rw, input bit go);
    int disp;
    m_chg = m_first;
    m_first = 0;
    if (gs) begin
      m_phase = 1; m_score = 0; m_nh = 0; m_chg = 1;
    end else if (go && m_phase == 1) begin
      m_phase = 2; m_t = 0; m_chg = 1;
      if (EN && m_score > m_high) begin m_high = m_score; m_nh = 1; end
    end else if (rw && m_phase == 1) begin
      m_score = (m_score + 1 > MAX) ? MAX : m_score + 1;
      m_chg = 1;
    end else if (m_phase == 2 && EN) begin
      m_t++;
      if (m_t % F == 0) m_chg = 1;
    end
    if (m_phase == 0) disp = EN ? m_high : 0;
    else if (m_phase == 1) disp = m_score;
    else disp = (EN && ((m_t / F) % 2 == 1)) ? m_high : m_score;
    if (m_chg) m_num = disp;
  endtask

  task automatic check_all();
    chk("change_score", change_score, m_chg);
    chk("number", number, m_num);
    chk("new_high", new_high, m_nh);
    chk("phase", phase, m_phase);
  endtask

  task automatic cyc(input bit gs, input bit rw, input bit go);
    game_start = gs; round_won = rw; game_over = go;
    @(posedge clock);
    model_step(gs, rw, go);
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  initial begin
    resetn = 1'b0; game_start = 1'b0; round_won = 1'b0; game_over = 1'b0;
    model_reset();
    #2 check_all();
    #5 resetn = 1'b1;
    idle(3);
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) begin cyc(0, 1, 0); cyc(0, 0, 0); end
    cyc(1, 0, 0);
    for (int i = 0; i < 105; i++) cyc(0, 1, 0);
    chk("saturated", number, MAX);
    idle(2);
    cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    cyc(0, 0, 1);
    chk("first_high_flag", new_high, EN);
    idle(10);
    cyc(1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 1, 0);
    cyc(0, 0, 1);
    idle(13);
    cyc(1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0);
    cyc(0, 1, 1);
    chk("over_drop_inc", number, 7);
    idle(2);
    cyc(1, 0, 1);
    chk("start_wins", number, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    idle(2);
    #1 resetn = 1'b0;
    model_reset();
    #1 check_all();
    #2 resetn = 1'b1;
    idle(3);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(99) < 2, $urandom_range(99) < 35, $urandom_range(99) < 6);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
